// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: default datapath width, the NOP encoding and
// the IF/ID skid-buffer state encoding.
package mips_pipe_pkg;

   localparam int DATA_W_DEFAULT = 32;

   // sll $0,$0,0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } ifid_state_t;

endpackage

// File: rtl/ifid_entry_reg.sv
// One IF/ID entry {pc, pc4, instr}: plain register with load enable and
// asynchronous active-high clear.
module ifid_entry_reg
   import mips_pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] d_pc,
   input  logic [DATA_W-1:0] d_pc4,
   input  logic [DATA_W-1:0] d_instr,
   output logic [DATA_W-1:0] q_pc,
   output logic [DATA_W-1:0] q_pc4,
   output logic [DATA_W-1:0] q_instr
);

   logic [DATA_W-1:0] pc_r;
   logic [DATA_W-1:0] pc4_r;
   logic [DATA_W-1:0] instr_r;

   // Entry storage, captured only when load is asserted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_r    <= {DATA_W{1'b0}};
         pc4_r   <= {DATA_W{1'b0}};
         instr_r <= {DATA_W{1'b0}};
      end else if (load) begin
         pc_r    <= d_pc;
         pc4_r   <= d_pc4;
         instr_r <= d_instr;
      end
   end

   assign q_pc    = pc_r;
   assign q_pc4   = pc4_r;
   assign q_instr = instr_r;

endmodule

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline boundary: two-entry skid buffer (head + skid) with valid/ready
// handshake and synchronous flush. Define IFID_PERF_CNT_EN to add stall/flush counters.
module ifid_skid_reg
   import mips_pipe_pkg::*;
#(
   parameter int                 DATA_W = DATA_W_DEFAULT,
   parameter logic [DATA_W-1:0]  NOP_W  = NOP_INSTR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_pc4,
   input  logic [DATA_W-1:0] in_instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_pc4,
   output logic [DATA_W-1:0] out_instr
`ifdef IFID_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   ifid_state_t state_r;
   ifid_state_t state_nxt_s;

   logic              push_s;
   logic              pop_s;
   logic              head_load_s;
   logic              head_from_skid_s;
   logic              skid_load_s;

   logic [DATA_W-1:0] head_pc_s;
   logic [DATA_W-1:0] head_pc4_s;
   logic [DATA_W-1:0] head_instr_s;
   logic [DATA_W-1:0] skid_pc_s;
   logic [DATA_W-1:0] skid_pc4_s;
   logic [DATA_W-1:0] skid_instr_s;
   logic [DATA_W-1:0] head_d_pc_s;
   logic [DATA_W-1:0] head_d_pc4_s;
   logic [DATA_W-1:0] head_d_instr_s;

   // Handshake flags are pure decodes of the state register.
   assign in_ready  = (state_r != FULL);
   assign out_valid = (state_r != EMPTY);
   assign push_s    = in_valid  & in_ready  & ~flush;
   assign pop_s     = out_valid & out_ready & ~flush;

   // Next-state and entry-load decode; flush overrides every transfer.
   always_comb begin
      state_nxt_s      = state_r;
      head_load_s      = 1'b0;
      head_from_skid_s = 1'b0;
      skid_load_s      = 1'b0;
      if (flush) begin
         state_nxt_s = EMPTY;
      end else begin
         case (state_r)
            EMPTY: begin
               if (push_s) begin
                  state_nxt_s = ONE;
                  head_load_s = 1'b1;
               end else begin
                  state_nxt_s = EMPTY;
               end
            end
            ONE: begin
               if (push_s && pop_s) begin
                  head_load_s = 1'b1;
               end else if (push_s) begin
                  state_nxt_s = FULL;
                  skid_load_s = 1'b1;
               end else if (pop_s) begin
                  state_nxt_s = EMPTY;
               end else begin
                  state_nxt_s = ONE;
               end
            end
            FULL: begin
               if (pop_s) begin
                  state_nxt_s      = ONE;
                  head_load_s      = 1'b1;
                  head_from_skid_s = 1'b1;
               end else begin
                  state_nxt_s = FULL;
               end
            end
            default: begin
               state_nxt_s = EMPTY;
            end
         endcase
      end
   end

   // Buffer occupancy state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   assign head_d_pc_s    = head_from_skid_s ? skid_pc_s    : in_pc;
   assign head_d_pc4_s   = head_from_skid_s ? skid_pc4_s   : in_pc4;
   assign head_d_instr_s = head_from_skid_s ? skid_instr_s : in_instr;

   ifid_entry_reg #(.DATA_W(DATA_W)) u_head (
      .clk     (clk),
      .reset   (reset),
      .load    (head_load_s),
      .d_pc    (head_d_pc_s),
      .d_pc4   (head_d_pc4_s),
      .d_instr (head_d_instr_s),
      .q_pc    (head_pc_s),
      .q_pc4   (head_pc4_s),
      .q_instr (head_instr_s)
   );

   ifid_entry_reg #(.DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load    (skid_load_s),
      .d_pc    (in_pc),
      .d_pc4   (in_pc4),
      .d_instr (in_instr),
      .q_pc    (skid_pc_s),
      .q_pc4   (skid_pc4_s),
      .q_instr (skid_instr_s)
   );

   // pc/pc4 hold their last value when empty; only the instruction is forced to NOP.
   assign out_pc    = head_pc_s;
   assign out_pc4   = head_pc4_s;
   assign out_instr = out_valid ? head_instr_s : NOP_W;

`ifdef IFID_PERF_CNT_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] flush_cnt_r;

   // Saturating stall and flush event counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
      end else begin
         if (out_valid && !out_ready && !flush && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (flush && (state_r != EMPTY) && (flush_cnt_r != 32'hFFFF_FFFF)) begin
            flush_cnt_r <= flush_cnt_r + 32'd1;
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Directed self-checking bench for ifid_skid_reg: stream, stall, flush, async reset
// and (with IFID_PERF_CNT_EN) the performance counters.
module tb_ifid_skid_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_pc4;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_pc4;
   logic [31:0] out_instr;
`ifdef IFID_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   int total = 0;
   int bad   = 0;

   ifid_skid_reg dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_pc4    (in_pc4),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_pc4   (out_pc4),
      .out_instr (out_instr)
`ifdef IFID_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present an entry; instruction word is derived from pc so it is distinct per entry.
   task automatic drive(input logic v, input logic [31:0] pc);
      in_valid = v;
      in_pc    = pc;
      in_pc4   = pc + 32'd4;
      in_instr = 32'h2000_0000 | pc;
   endtask

   // Advance one rising edge and return at the following falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_out_pc",    out_pc,    32'h0);
      chk("rst_out_pc4",   out_pc4,   32'h0);

      // Stream with ID always ready
      out_ready = 1'b1;
      drive(1'b1, 32'h0); cyc();
      chk("str0_valid", {31'd0, out_valid}, 32'd1);
      chk("str0_pc",    out_pc,    32'h0);
      chk("str0_pc4",   out_pc4,   32'h4);
      chk("str0_instr", out_instr, 32'h2000_0000);
      chk("str0_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 32'h4); cyc();
      chk("str1_pc",    out_pc,    32'h4);
      chk("str1_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 32'h8); cyc();
      chk("str2_pc",    out_pc,    32'h8);
      chk("str2_instr", out_instr, 32'h2000_0008);
      drive(1'b0, 32'h0); cyc();
      chk("str_drain_valid", {31'd0, out_valid}, 32'd0);
      chk("str_drain_instr", out_instr, 32'h0);
      chk("str_hold_pc",     out_pc,    32'h8);

      // Stall: fill to FULL, then release
      out_ready = 1'b0;
      drive(1'b1, 32'h100); cyc();
      chk("stl0_pc",    out_pc, 32'h100);
      chk("stl0_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 32'h104); cyc();
      chk("stl_full_ready", {31'd0, in_ready},  32'd0);
      chk("stl_full_valid", {31'd0, out_valid}, 32'd1);
      chk("stl_full_pc",    out_pc, 32'h100);
      drive(1'b1, 32'h108); cyc();
      chk("stl_hold_pc",    out_pc,    32'h100);
      chk("stl_hold_instr", out_instr, 32'h2000_0100);
      drive(1'b0, 32'h0); out_ready = 1'b1; cyc();
      chk("stl_rel1_pc",    out_pc, 32'h104);
      chk("stl_rel1_pc4",   out_pc4, 32'h108);
      chk("stl_rel1_ready", {31'd0, in_ready}, 32'd1);
      cyc();
      chk("stl_rel2_valid", {31'd0, out_valid}, 32'd0);

      // Flush while FULL, with a new entry offered the same cycle
      out_ready = 1'b0;
      drive(1'b1, 32'h180); cyc();
      drive(1'b1, 32'h184); cyc();
      chk("fl_full_ready", {31'd0, in_ready}, 32'd0);
      flush = 1'b1; drive(1'b1, 32'h200); cyc();
      flush = 1'b0; drive(1'b0, 32'h0);
      chk("fl_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_instr", out_instr, 32'h0);
      chk("fl_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1; cyc();
      chk("fl_no200_valid", {31'd0, out_valid}, 32'd0);

      // Flush and pop in the same cycle while ONE
      out_ready = 1'b0;
      drive(1'b1, 32'h280); cyc();
      chk("fp_one_pc", out_pc, 32'h280);
      drive(1'b0, 32'h0); flush = 1'b1; out_ready = 1'b1; cyc();
      flush = 1'b0;
      chk("fp_empty_valid", {31'd0, out_valid}, 32'd0);
      drive(1'b1, 32'h300); cyc();
      chk("fp_300_valid", {31'd0, out_valid}, 32'd1);
      chk("fp_300_pc",    out_pc, 32'h300);
      drive(1'b0, 32'h0); cyc();
      chk("fp_300_pop", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset asserted mid-cycle while FULL
      out_ready = 1'b0;
      drive(1'b1, 32'h500); cyc();
      drive(1'b1, 32'h504); cyc();
      drive(1'b0, 32'h0);
      chk("ar_full_ready", {31'd0, in_ready}, 32'd0);
      #2 reset = 1'b1;
      #1;
      chk("ar_valid", {31'd0, out_valid}, 32'd0);
      chk("ar_ready", {31'd0, in_ready},  32'd1);
      chk("ar_instr", out_instr, 32'h0);
      chk("ar_pc",    out_pc,    32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

`ifdef IFID_PERF_CNT_EN
      chk("pc_rst_stall", stall_cnt, 32'd0);
      chk("pc_rst_flush", flush_cnt, 32'd0);
      out_ready = 1'b0;
      drive(1'b1, 32'h400); cyc();
      drive(1'b0, 32'h0);
      repeat (5) cyc();
      chk("pc_stall5", stall_cnt, 32'd5);
      flush = 1'b1; cyc();
      flush = 1'b0;
      drive(1'b1, 32'h404); cyc();
      drive(1'b0, 32'h0); flush = 1'b1; cyc();
      flush = 1'b0;
      chk("pc_flush2", flush_cnt, 32'd2);
      chk("pc_stall_after", stall_cnt, 32'd5);
      flush = 1'b1; cyc();
      flush = 1'b0;
      chk("pc_flush_empty", flush_cnt, 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
